// File: rtl/matrix_line_fetch.sv
// Line fetcher for the RGB matrix codec: walks the row pairs, reads one line
// word per row pair from synchronous frame memory and holds it until the codec is done.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for run; line counter parked at 0
// READ    | mem_rd strobe with mem_addr = line
// WAIT    | read data arrives; captured into m_data/linesel on exit
// PRESENT | r_enable high, waiting for line_done
// BLANK   | inter-line gap, down-counter from BLANK_CYC to 1
// NEXT    | advance line; at the last line close the frame
module matrix_line_fetch #(
  parameter int N_LINES   = 8,
  parameter int SEL_W     = 3,
  parameter int LINE_W    = 96,
  parameter int BLANK_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              mem_rd,
  output logic [SEL_W-1:0]  mem_addr,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic [0:LINE_W-1] m_data,
  output logic [0:SEL_W-1]  linesel,
  output logic              r_enable,
  input  logic              line_done,
  output logic              frame_done,
  output logic [7:0]        frame_cnt,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_PRESENT,
    S_BLANK,
    S_NEXT
  } state_t;

  localparam logic [SEL_W-1:0] LAST_LINE  = SEL_W'(N_LINES - 1);
  localparam logic [7:0]       BLANK_LOAD = 8'(BLANK_CYC);

  state_t           state;
  state_t           state_nxt;
  logic [SEL_W-1:0] line;
  logic [7:0]       blank_cnt;
  logic             last_line;

  assign last_line = (line == LAST_LINE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (run) state_nxt = S_READ;
      S_READ:    state_nxt = S_WAIT;
      S_WAIT:    state_nxt = S_PRESENT;
      S_PRESENT: begin
        if (line_done) state_nxt = (BLANK_CYC == 0) ? S_NEXT : S_BLANK;
      end
      S_BLANK:   if (blank_cnt <= 8'd1) state_nxt = S_NEXT;
      // frames are atomic: run only matters once the last line has been closed
      S_NEXT: begin
        if (last_line) state_nxt = run ? S_READ : S_IDLE;
        else           state_nxt = S_READ;
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_rd   = (state == S_READ);
    mem_addr = (state == S_READ) ? line : '0;
    r_enable = (state == S_PRESENT);
    busy     = (state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      line       <= '0;
      blank_cnt  <= '0;
      m_data     <= '0;
      linesel    <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      frame_done <= 1'b0;

      if (state == S_WAIT) begin
        m_data  <= mem_rdata;
        linesel <= line;
      end

      if (state == S_PRESENT && line_done) blank_cnt <= BLANK_LOAD;
      else if (state == S_BLANK)           blank_cnt <= blank_cnt - 8'd1;

      if (state == S_NEXT) begin
        if (last_line) begin
          line       <= '0;
          frame_done <= 1'b1;
          frame_cnt  <= frame_cnt + 8'd1;
        end else begin
          line <= line + SEL_W'(1);
        end
      end
    end
  end

endmodule
